// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial adder: {cout,sum} = a + b + cin computed one byte per cycle
// through a single shared 8-bit ripple-carry adder.

module Ripple_Carry_Adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [7:0] sum
);
    logic [8:0] carry;

    always_comb begin
        // NOTE: blocking assignments in combinational logic so each carry feeds the next bit in the same pass.
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[8];
    end
endmodule

module byte_serial_adder_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW+2:0]   bofs;
    logic            c;
    logic [W-1:0]    la;
    logic [W-1:0]    lb;
    logic [W-1:0]    partial;
    logic [W-1:0]    full;
    logic [7:0]      rsum;
    logic            rcout;

    assign bofs = {idx, 3'b000};

    Ripple_Carry_Adder u_rca (
        .a    (la[bofs +: 8]),
        .b    (lb[bofs +: 8]),
        .cin  (c),
        .cout (rcout),
        .sum  (rsum)
    );

    // Partial result with the byte being computed this cycle merged in,
    // so the final edge can publish all bytes at once.
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
        full             = partial;
        full[bofs +: 8]  = rsum;
    end

    // NOTE: every register, including the operand/partial-result storage, is cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            c       <= 1'b0;
            la      <= '0;
            lb      <= '0;
            partial <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all sequential state so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (start) begin
                        la    <= a;
                        lb    <= b;
                        c     <= cin;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    partial[bofs +: 8] <= rsum;
                    c                  <= rcout;
                    if (idx == LAST) begin
                        sum   <= full;
                        cout  <= rcout;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Directed self-checking bench for byte_serial_adder_ctrl with NBYTES=4.

module tb_byte_serial_adder_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;

    int tests;
    int fails;
    logic [31:0] prev_sum;
    logic        prev_cout;

    byte_serial_adder_ctrl #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (sum !== 32'h0) begin fails++; $display("FAIL reset_sum: got %h want 00000000", sum); end
        tests++; if (cout !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout); end
        rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
    endtask

    // mode 0: plain; 1: re-assert start with a=b=1 during RUN; 2: change a to 0 after accept.
    task automatic run_add(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tc, input logic [31:0] es, input logic ec, input int mode);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (mode == 2) a = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mode == 1 && i == 0) begin start = 1'b1; a = 32'h1; b = 32'h1; end
            if (mode == 1 && i == 2) start = 1'b0;
            tests++; if (busy !== 1'b1 || done !== 1'b0) begin
                fails++; $display("FAIL %s_run%0d: busy=%b done=%b want busy=1 done=0", name, i, busy, done);
            end
            tests++; if (sum !== prev_sum || cout !== prev_cout) begin
                fails++; $display("FAIL %s_hold%0d: sum=%h cout=%b want %h %b", name, i, sum, cout, prev_sum, prev_cout);
            end
            @(posedge clk);
        end
        @(negedge clk);
        tests++; if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL %s_done: done=%b busy=%b want done=1 busy=0", name, done, busy);
        end
        tests++; if (sum !== es) begin fails++; $display("FAIL %s_sum: got %h want %h", name, sum, es); end
        tests++; if (cout !== ec) begin fails++; $display("FAIL %s_cout: got %b want %b", name, cout, ec); end
        prev_sum = es; prev_cout = ec;
        @(negedge clk);
        tests++; if (done !== 1'b0 || sum !== es || cout !== ec) begin
            fails++; $display("FAIL %s_after: done=%b sum=%h cout=%b want 0 %h %b", name, done, sum, cout, es, ec);
        end
        if (mode == 1) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                tests++; if (done !== 1'b0 || busy !== 1'b0) begin
                    fails++; $display("FAIL %s_noqueue%0d: done=%b busy=%b want 0 0", name, i, done, busy);
                end
            end
        end
    endtask

    task automatic test_carry_chain();
        run_add("carry_chain", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 0);
    endtask

    task automatic test_cin();
        run_add("cin", 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 0);
    endtask

    task automatic test_start_ignored();
        run_add("ignore_start", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1);
    endtask

    task automatic test_operand_change();
        run_add("operand_change", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 2);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a = 32'h11223344; b = 32'h55667788; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL midrst_flags: busy=%b done=%b want 0 0", busy, done);
        end
        tests++; if (sum !== 32'h0 || cout !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs: sum=%h cout=%b want 00000000 0", sum, cout);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (done !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL midrst_nodone%0d: done=%b busy=%b want 0 0", i, done, busy);
            end
        end
        rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
        run_add("post_reset", 32'hDEADBEEF, 32'h01020304, 1'b1, 32'hDFAFC1F4, 1'b0, 0);
        run_add("top_carry", 32'hF0000000, 32'h20000000, 1'b0, 32'h10000000, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        logic exp_busy;
        @(negedge clk);
        a = 32'h1; b = 32'h2; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 18; n++) begin
            @(negedge clk);
            exp_done = ((n % 6) == 4);
            exp_busy = ((n % 6) < 4);
            tests++; if (done !== exp_done || busy !== exp_busy) begin
                fails++; $display("FAIL b2b_cycle%0d: done=%b busy=%b want %b %b", n, done, busy, exp_done, exp_busy);
            end
            if (exp_done) begin
                tests++; if (sum !== 32'h3 || cout !== 1'b0) begin
                    fails++; $display("FAIL b2b_result%0d: sum=%h cout=%b want 00000003 0", n, sum, cout);
                end
            end
            @(posedge clk);
        end
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_carry_chain();
        test_cin();
        test_start_ignored();
        test_operand_change();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/byte_serial_adder_ctrl.md
BYTE_SERIAL_ADDER_CTRL -- requirements
Module: byte_serial_adder_ctrl

Interface
REQ-001 Parameter NBYTES, default 4: operand width in bytes; legal range 2..8.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one addition; sampled only in IDLE.
REQ-005 a  input  8*NBYTES  operand A; sampled on the accepting edge only.
REQ-006 b  input  8*NBYTES  operand B; sampled on the accepting edge only.
REQ-007 cin  input  1  carry-in to byte 0; sampled on the accepting edge only.
REQ-008 busy  output  1  high while a byte-serial addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  8*NBYTES  registered result; holds until the next completion.
REQ-011 cout  output  1  registered carry-out of the most significant byte.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin using exactly one instance of the team's 8-bit Ripple_Carry_Adder, time-shared across bytes. Port order is (a, b, cin, cout, sum).
REQ-013 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
REQ-014 In IDLE with start=1, the edge SHALL latch a, b and cin into internal registers, clear byte index idx to 0, and move to RUN.
REQ-015 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-016 In RUN, the adder inputs SHALL be latched A byte idx, latched B byte idx, and carry register c. Byte idx is bits [8*idx+7:8*idx].
REQ-017 Each RUN edge SHALL write the adder sum into partial-result byte idx, load c with the adder cout, and increment idx.
REQ-018 On the RUN edge where idx = NBYTES-1, the FSM SHALL move to DONE. On that same edge it SHALL load the sum output with the full partial result (including the final byte) and load the cout output with the final carry.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both SHALL be 0 in IDLE.
REQ-021 Latency: the edge accepting start is edge 0. done SHALL be high in the cycle following edge NBYTES.
REQ-022 Throughput: one addition per NBYTES+2 cycles, since start is accepted only in IDLE.
REQ-023 start during RUN or DONE SHALL be ignored. It SHALL NOT be queued and SHALL NOT alter latched operands.
REQ-024 Changes on a, b or cin after the accepting edge SHALL NOT affect the result in progress.
REQ-025 The sum and cout outputs SHALL change only on the RUN-to-DONE edge or on reset. Intermediate bytes SHALL NOT be visible on sum.
REQ-026 Overflow wraps modulo 2^(8*NBYTES). The carry out of the top byte appears only on cout.
REQ-027 idx SHALL be sized ceil(log2(NBYTES)) bits or wider and SHALL never exceed NBYTES-1.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and clear idx, c, latched operands, sum, cout, busy and done to 0.
REQ-029 Reset mid-RUN SHALL abort the operation with no done pulse. The partial result SHALL be discarded.
REQ-030 After rst_n rises, the first start SHALL be accepted on the first rising edge where it is sampled high.

Verification (NBYTES=4)
REQ-031 a=32'hFFFFFFFF, b=32'h00000001, cin=0, start pulsed -> busy high for 4 cycles, done high in cycle 5, sum=32'h00000000, cout=1.
REQ-032 a=32'h12345678, b=32'h11111111, cin=1 -> sum=32'h2345678A, cout=0. sum SHALL hold its prior value until done.
REQ-033 a=32'h80000000, b=32'h80000000, cin=0; then start re-asserted with a=b=32'h1 during RUN -> sum=0, cout=1. The second start SHALL be ignored: no second done.
REQ-034 Start with a=32'h0000FFFF, b=32'h00000001, cin=0; then change a to 32'h0 on the next cycle -> sum=32'h00010000, cout=0.
REQ-035 Start, then drop rst_n to 0 after 2 RUN edges -> busy, done, sum, cout all 0 at once, with no done pulse. A new start after release yields a correct result.
REQ-036 Hold start=1 continuously with a=1, b=2, cin=0 -> done pulses every 6 cycles with sum=32'h00000003, cout=0.
